// File: rtl/scaledclock_monitor.sv
// Receive-side monitor for a divided clock: synchronizes it into the fast clock domain, emits
// edge ticks, measures each half-period and tracks lock/loss against an expected half-period.
module scaledclock_monitor #(
    parameter int unsigned EXP_HALF   = 50,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             scaledclk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned      MatchW     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TolLo      = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] TolHi      = CNT_W'(EXP_HALF + TOL);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(EXP_HALF + TOL + 1);
    localparam logic [MatchW-1:0] LockLast  = MatchW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StHunt, StLocked, StLost} state_e;

    state_e            state;
    logic              s1, s2, s3;
    logic [CNT_W-1:0]  cnt;
    logic              primed;
    logic [MatchW-1:0] match;

    logic sc_edge, sc_rise, sc_fall, in_tol, meas, timeout;

    assign sc_edge = s2 ^ s3;
    assign sc_rise = s2 & ~s3;
    assign sc_fall = ~s2 & s3;
    // A saturated count is never a believable half-period, whatever the window.
    assign in_tol  = (cnt >= TolLo) && (cnt <= TolHi) && (cnt != '1);
    assign meas    = sc_edge & enable & primed;
    assign timeout = ~sc_edge & (cnt == TimeoutCnt);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= scaledclk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || !enable) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (sc_edge) begin
            cnt    <= CNT_W'(1);
            primed <= 1'b1;
        end else if (cnt != '1) begin
            cnt    <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= StIdle;
            match       <= '0;
            locked      <= 1'b0;
            lost        <= 1'b0;
            half_period <= '0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
        end else begin
            rise_tick <= sc_rise & enable;
            fall_tick <= sc_fall & enable;
            if (meas) half_period <= cnt;

            if (!enable) begin
                state  <= StIdle;
                match  <= '0;
                locked <= 1'b0;
                lost   <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: state <= StHunt;
                    StHunt: begin
                        if (meas) begin
                            if (in_tol) begin
                                match <= match + 1'b1;
                                if (match == LockLast) begin
                                    state  <= StLocked;
                                    locked <= 1'b1;
                                end
                            end else begin
                                match <= '0;
                            end
                        end
                    end
                    StLocked: begin
                        // An edge in the threshold cycle is judged on its measurement alone.
                        if ((meas && !in_tol) || timeout) begin
                            state  <= StLost;
                            locked <= 1'b0;
                            lost   <= 1'b1;
                        end
                    end
                    StLost: begin
                        if (sc_edge) begin
                            state <= StHunt;
                            match <= (meas && in_tol) ? MatchW'(1) : '0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scaledclock_monitor.sv
// Directed bench for scaledclock_monitor at default parameters (expected 50, tolerance 2,
// lock after 4 matches, 8-bit counter); every expectation is a hand-derived constant.
module tb_scaledclock_monitor;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       scaledclk = 1'b0;
    logic       rise_tick, fall_tick, locked, lost;
    logic [7:0] half_period;

    int checks = 0;
    int errors = 0;

    scaledclock_monitor dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .scaledclk   (scaledclk),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .half_period (half_period),
        .locked      (locked),
        .lost        (lost)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Advance n clocks and settle just past the last posedge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = 1'b1;
        scaledclk = 1'b0;
        step(2);
        resetn = 1'b1;
        step(3);
    endtask

    // Five 50-cycle half-periods; returns on the sample where the 5th edge's tick is visible.
    task automatic lock_up();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            scaledclk = ~scaledclk;
            step(3);
            if (i < 4) step(47);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            enable = (i % 2 == 1);
            scaledclk = ~scaledclk;
            step(1);
            checks++;
            if ({rise_tick, fall_tick, locked, lost} !== 4'b0000 || half_period !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: rise=%b fall=%b hp=%0d locked=%b lost=%b, want all 0",
                         i, rise_tick, fall_tick, half_period, locked, lost);
            end
        end
        scaledclk = 1'b0;
        enable = 1'b1;
        step(1);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({rise_tick, fall_tick, locked, lost} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release cycle %0d: rise=%b fall=%b locked=%b lost=%b, want 0",
                         i, rise_tick, fall_tick, locked, lost);
            end
        end
    endtask

    task automatic test_nominal();
        logic [7:0] exp_hp;
        do_reset();
        for (int e = 0; e < 7; e++) begin
            scaledclk = ~scaledclk;
            step(3);
            exp_hp = (e == 0) ? 8'd0 : 8'd50;
            checks++;
            if (rise_tick !== scaledclk || fall_tick !== ~scaledclk) begin
                errors++;
                $display("FAIL nominal_tick edge %0d: rise=%b fall=%b, want rise=%b fall=%b",
                         e, rise_tick, fall_tick, scaledclk, ~scaledclk);
            end
            checks++;
            if (half_period !== exp_hp) begin
                errors++;
                $display("FAIL nominal_hp edge %0d: got %0d want %0d", e, half_period, exp_hp);
            end
            checks++;
            if (locked !== (e >= 4) || lost !== 1'b0) begin
                errors++;
                $display("FAIL nominal_lock edge %0d: locked=%b lost=%b, want locked=%b lost=0",
                         e, locked, lost, (e >= 4));
            end
            step(1);
            checks++;
            if (rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
                errors++;
                $display("FAIL nominal_pulse edge %0d: rise=%b fall=%b, want 0 0",
                         e, rise_tick, fall_tick);
            end
            step(46);
        end
    endtask

    task automatic test_tolerance();
        int   la [6] = '{48, 52, 48, 52, 53, 50};
        int   ha [6] = '{0, 48, 52, 48, 52, 53};
        logic ka [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic sa [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   lb [7] = '{53, 47, 50, 50, 50, 47, 50};
        int   hb [7] = '{0, 53, 47, 50, 50, 50, 47};
        do_reset();
        for (int e = 0; e < 6; e++) begin
            scaledclk = ~scaledclk;
            step(3);
            checks++;
            if (half_period !== 8'(ha[e]) || locked !== ka[e] || lost !== sa[e]) begin
                errors++;
                $display("FAIL tol_edge edge %0d: hp=%0d locked=%b lost=%b, want hp=%0d locked=%b lost=%b",
                         e, half_period, locked, lost, ha[e], ka[e], sa[e]);
            end
            step(la[e] - 3);
        end
        do_reset();
        for (int e = 0; e < 7; e++) begin
            scaledclk = ~scaledclk;
            step(3);
            checks++;
            if (half_period !== 8'(hb[e]) || locked !== 1'b0 || lost !== 1'b0) begin
                errors++;
                $display("FAIL tol_out edge %0d: hp=%0d locked=%b lost=%b, want hp=%0d locked=0 lost=0",
                         e, half_period, locked, lost, hb[e]);
            end
            step(lb[e] - 3);
        end
    endtask

    task automatic test_timeout();
        lock_up();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL timeout_prelock: locked=%b want 1", locked);
        end
        step(52);
        checks++;
        if (locked !== 1'b1 || lost !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: locked=%b lost=%b, want 1 0", locked, lost);
        end
        step(1);
        checks++;
        if (locked !== 1'b0 || lost !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: locked=%b lost=%b, want 0 1", locked, lost);
        end
        for (int r = 0; r < 5; r++) begin
            scaledclk = ~scaledclk;
            step(3);
            checks++;
            if (half_period !== ((r == 0) ? 8'd56 : 8'd50) || locked !== (r == 4) || lost !== 1'b1) begin
                errors++;
                $display("FAIL timeout_relock edge %0d: hp=%0d locked=%b lost=%b, want hp=%0d locked=%b lost=1",
                         r, half_period, locked, lost, (r == 0) ? 56 : 50, (r == 4));
            end
            step(47);
        end
    endtask

    task automatic test_enable_overflow();
        int lo [3] = '{300, 300, 300};
        lock_up();
        step(53);
        checks++;
        if (lost !== 1'b1) begin
            errors++;
            $display("FAIL enable_prelost: lost=%b want 1", lost);
        end
        enable = 1'b0;
        step(1);
        checks++;
        if (locked !== 1'b0 || lost !== 1'b0 || half_period !== 8'd50) begin
            errors++;
            $display("FAIL enable_clear: locked=%b lost=%b hp=%0d, want 0 0 50", locked, lost, half_period);
        end
        for (int i = 0; i < 3; i++) begin
            scaledclk = ~scaledclk;
            step(3);
            checks++;
            if (rise_tick !== 1'b0 || fall_tick !== 1'b0 || half_period !== 8'd50) begin
                errors++;
                $display("FAIL enable_quiet toggle %0d: rise=%b fall=%b hp=%0d, want 0 0 50",
                         i, rise_tick, fall_tick, half_period);
            end
            step(5);
        end
        lock_up();
        enable = 1'b0;
        step(1);
        checks++;
        if (locked !== 1'b0 || lost !== 1'b0) begin
            errors++;
            $display("FAIL enable_locked_drop: locked=%b lost=%b, want 0 0", locked, lost);
        end
        do_reset();
        for (int e = 0; e < 3; e++) begin
            scaledclk = ~scaledclk;
            step(3);
            checks++;
            if (half_period !== ((e == 0) ? 8'd0 : 8'd255) || locked !== 1'b0) begin
                errors++;
                $display("FAIL overflow edge %0d: hp=%0d locked=%b, want hp=%0d locked=0",
                         e, half_period, locked, (e == 0) ? 0 : 255);
            end
            step(lo[e] - 3);
        end
    endtask

    task automatic test_mid_reset();
        lock_up();
        resetn = 1'b0;
        step(1);
        checks++;
        if ({rise_tick, fall_tick, locked, lost} !== 4'b0000 || half_period !== 8'd0) begin
            errors++;
            $display("FAIL midreset_out: rise=%b fall=%b hp=%0d locked=%b lost=%b, want all 0",
                     rise_tick, fall_tick, half_period, locked, lost);
        end
        resetn = 1'b1;
        step(3);
        checks++;
        if (rise_tick !== 1'b1 || half_period !== 8'd0) begin
            errors++;
            $display("FAIL midreset_prime: rise=%b hp=%0d, want 1 0", rise_tick, half_period);
        end
        scaledclk = ~scaledclk;
        step(3);
        checks++;
        if (fall_tick !== 1'b1 || half_period !== 8'd3 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midreset_meas: fall=%b hp=%0d locked=%b, want 1 3 0",
                     fall_tick, half_period, locked);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_tolerance();
        test_timeout();
        test_enable_overflow();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaledclock_monitor.md
# scaledclock_monitor

Receive-side companion to the scaled-clock divider: samples a divided clock (`scaledclk`) in the fast `clock` domain, converts its edges into one-cycle ticks, measures each half-period in `clock` cycles, and reports lock or loss against an expected half-period. It sits beside every divider consumer, so that logic can run on `clock` with tick enables and report a stalled or mis-scaled divider.

## Interface
Parameters:
- `EXP_HALF`, default 50: expected half-period in `clock` cycles.
- `TOL`, default 2: allowed absolute deviation; a measurement m is in tolerance iff EXP_HALF−TOL ≤ m ≤ EXP_HALF+TOL.
- `LOCK_COUNT`, default 4: consecutive in-tolerance measurements required to lock.
- `CNT_W`, default 8: width of the measurement counter and of `half_period`.

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `enable` in 1: monitor enable. Low means idle and clear.
- `scaledclk` in 1: divided clock, asynchronous to this block's sampling.
- `rise_tick` out 1: one-cycle pulse per synchronized rising edge.
- `fall_tick` out 1: one-cycle pulse per synchronized falling edge.
- `half_period` out CNT_W: last valid measurement.
- `locked` out 1: divider running within tolerance.
- `lost` out 1: sticky fault flag.

## Operation
- Synchronizer: two flops s1→s2, then a history flop s3. The synchronizer runs regardless of `enable`. An edge is s2≠s3; rise is s2&~s3, fall is ~s2&s3.
- Ticks are registered as rise/fall AND `enable`.
- Counter `cnt` (CNT_W bits):
  - On an edge cycle, next value is 1.
  - Otherwise it increments, saturating at 2^CNT_W−1.
  - When `enable` is low, it is held at 0.
- Measurement: on an edge cycle, m = cnt. The first edge after `enable` rises or after reset only primes the counter and yields no measurement. Each later edge updates `half_period` to m.
- States: IDLE, HUNT, LOCKED, LOST.
  - IDLE: `enable` low; match count 0, `locked` 0, `lost` 0, primed flag cleared. Goes to HUNT when `enable` is high.
  - HUNT: each measurement in tolerance increments the match count; a measurement out of tolerance zeroes it. When the match count reaches LOCK_COUNT, go to LOCKED.
  - LOCKED: go to LOST on an out-of-tolerance measurement, or on timeout. Timeout is cnt reaching EXP_HALF+TOL+1 with no edge in that cycle.
  - LOST: go to HUNT on the next edge. The match count is set to 1 if that measurement is in tolerance, else 0.
- `lost` is set on any entry to LOST. It stays set through HUNT and LOCKED and clears only on reset or `enable` low.
- `enable` low from any state goes to IDLE the next cycle.
- Measurement overflow: a saturated cnt (2^CNT_W−1) is a valid measurement. It is always out of tolerance and is reported as-is.
- Simultaneous edge and timeout threshold in the same cycle: the edge wins. The measurement is evaluated and the timeout is ignored.

## Timing
- Reset (resetn=0 at posedge): s1, s2, s3 = 0; cnt = 0; state IDLE; all outputs 0, including `half_period` = 0.
- Reset mid-operation behaves identically to power-up reset, taking effect on the next posedge.
- A `scaledclk` change first sampled at posedge k drives `rise_tick`/`fall_tick` high for exactly the cycle after posedge k+2.
- `half_period`, `locked` and `lost` update at the same posedge as the tick asserts.
- The timeout-driven change (`locked` falls, `lost` rises) is registered at the posedge after cnt equals EXP_HALF+TOL+1.
- With `enable` low, `half_period` holds its last value; ticks, `locked` and `lost` are 0.
- Outputs are all registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold resetn=0 while toggling `scaledclk` and `enable` → all outputs 0 and `half_period`=0. Release with enable=1 and no toggling → state HUNT, no ticks.
- Nominal lock: `scaledclk` toggles every 50 cycles → ticks alternate rise/fall 50 cycles apart, `half_period`=50, `locked`=1 with the tick of the 5th edge, `lost`=0.
- Tolerance boundary: half-periods 48 and 52 → lock is reached. Half-periods of 53 or 47 → match count resets and `locked` never asserts. After lock, a single 53 → `locked`=0, `lost`=1.
- Timeout: lock, then freeze `scaledclk` → `locked` falls and `lost` rises 53 cycles after the last edge. Resuming 50-cycle toggling → relock after 4 measurements with `lost` still 1.
- Enable/overflow: deassert `enable` while locked → next cycle `locked`=`lost`=0 and ticks suppressed. With CNT_W=8, a 300-cycle half-period → `half_period`=255 and no lock.
- Mid-operation reset: assert resetn=0 for one cycle while LOCKED → all outputs 0 next cycle. The first post-reset edge yields no measurement.
